pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage CPU (IF/ID/EX/MEM/WB).
- Generates per-stage stall/flush for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and gates external interrupts into the EX-stage `int_detect` input.
- Commits exceptions and exception returns at MEM, and holds the exception control registers (EPC, cause, interrupt enable).
- Drives the redirect PC to the fetch unit.

Parameters:
- EXP_VECTOR, 30'h0000_0100, word address of the exception handler.
- FLUSH_CYCLES, 1, cycles that flush stays asserted after a redirect (1..7).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- if_busy  in  1  fetch bus access not complete.
- mem_busy  in  1  data bus access not complete.
- ld_hazard  in  1  load-use hazard detected in ID.
- irq  in  1  level interrupt request, already synchronised.
- mem_pc  in  30  PC of the instruction in MEM.
- mem_en  in  1  MEM instruction valid.
- mem_br_flag  in  1  MEM instruction is in a branch delay slot.
- mem_exp_code  in  3  exception code (0 none, 1 ext int, 2 undef, 3 overflow, 4 misalign, 5 trap, 6 privilege).
- mem_ctrl_op  in  2  0 NOP, 1 WRCR, 2 EXRT.
- mem_cr_addr  in  2  control register select (0 status, 1 cause, 2 epc).
- mem_cr_wdata  in  32  WRCR data.
- if_stall, id_stall, ex_stall, mem_stall  out  1 each  stage hold.
- if_flush, id_flush, ex_flush, mem_flush  out  1 each  stage bubble insert.
- new_pc  out  30  redirect target; valid while if_flush=1.
- int_detect  out  1  interrupt accepted; routed to the EX register.
- int_en  out  1  status bit 0.
- epc  out  30  saved exception PC.
- exp_cause  out  3  last committed exception code.

Behaviour:
- Reset (synchronous, reset=1 at rising edge):
  - state=RUN, int_en=0, pre_int_en=0, epc=0, exp_cause=0, flush counter=0.
  - All stall/flush outputs=0, new_pc=0, int_detect=0.
- Stall is combinational. Let bus_stall = if_busy | mem_busy.
  - bus_stall=1: all four stalls=1.
  - ld_hazard=1 with bus_stall=0: if_stall=id_stall=1 and ex_flush=1 (bubble); ex_stall=mem_stall=0.
- Commit event, evaluated in RUN only and only when mem_stall=0 and mem_en=1:
  - exp: mem_exp_code!=0.
  - eret: mem_ctrl_op=EXRT with no exception.
  - wrcr: mem_ctrl_op=WRCR with no exception.
  - Priority: exp > eret > wrcr.
- On exp:
  - epc <= mem_br_flag ? mem_pc-1 : mem_pc. Arithmetic is 30-bit and wraps (0-1 = 30'h3FFF_FFFF).
  - exp_cause <= mem_exp_code; pre_int_en <= int_en; int_en <= 0.
  - redirect target <= EXP_VECTOR; state <= FLUSH.
- On eret: int_en <= pre_int_en; redirect target <= epc; state <= FLUSH.
- On wrcr:
  - addr 0 writes int_en<=wdata[0] and pre_int_en<=wdata[1].
  - addr 1 writes exp_cause<=wdata[2:0].
  - addr 2 writes epc<=wdata[31:2].
  - addr 3 is ignored. No redirect.
- FLUSH state:
  - All four flushes=1 and new_pc=target, for FLUSH_CYCLES cycles in which bus_stall=0. Cycles with bus_stall=1 do not count.
  - Stall outputs still follow bus_stall; the stage registers give stall priority over flush.
  - Counter reaches FLUSH_CYCLES → state <= RUN, flushes drop the next cycle.
  - No new commit, interrupt or WRCR is accepted while in FLUSH.
- int_detect = irq & int_en & (state==RUN) & ~bus_stall & ~ld_hazard (combinational).
  - The accepted interrupt reaches MEM as exp_code 1 and commits as a normal exception.
  - Because int_en is cleared at commit, a held irq does not re-enter.
- Simultaneous eret and irq in the same cycle: eret wins (state leaves RUN, so int_detect=0 next cycle). irq is re-sampled after FLUSH.
- reset asserted mid-FLUSH: state returns to RUN immediately. The redirect is abandoned and all registers take their reset values.

Test Plan:
- Overflow at MEM: reset, int_en=1, mem_en=1, mem_pc=30'h40, mem_exp_code=3, mem_br_flag=0 → next cycle all flushes=1, new_pc=30'h100, epc=30'h40, exp_cause=3, int_en=0; flushes=0 one cycle later.
- Delay-slot exception with wrap: mem_pc=0, mem_br_flag=1, mem_exp_code=5 → epc=30'h3FFF_FFFF; then EXRT at MEM → new_pc=30'h3FFF_FFFF, int_en restored to 1.
- Load-use hazard: ld_hazard=1, busy=0 → if_stall=id_stall=1, ex_flush=1, ex_stall=mem_stall=0. With mem_busy=1 added → all stalls=1.
- Interrupt gating: irq=1, int_en=0 → int_detect=0. WRCR addr0 data 1 → int_detect=1 next cycle. Commit exp_code 1 → int_en=0, int_detect=0 while irq is held.
- Stalled flush, FLUSH_CYCLES=2: exception commits, then mem_busy=1 for 3 cycles during FLUSH → flushes stay high for exactly 2 non-stalled cycles (5 cycles total); a commit presented during FLUSH is ignored.
- Reset mid-FLUSH: reset=1 on the second FLUSH cycle → next cycle all outputs are 0 and state=RUN; a subsequent exception is handled normally.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: MEM-stage commit inputs, hazard/bus status,
// and the stall/flush/redirect/exception-register outputs of pipe_ctrl.
interface pipe_ctrl_if;
  logic        if_busy;
  logic        mem_busy;
  logic        ld_hazard;
  logic        irq;
  logic [29:0] mem_pc;
  logic        mem_en;
  logic        mem_br_flag;
  logic [2:0]  mem_exp_code;
  logic [1:0]  mem_ctrl_op;
  logic [1:0]  mem_cr_addr;
  logic [31:0] mem_cr_wdata;

  logic        if_stall;
  logic        id_stall;
  logic        ex_stall;
  logic        mem_stall;
  logic        if_flush;
  logic        id_flush;
  logic        ex_flush;
  logic        mem_flush;
  logic [29:0] new_pc;
  logic        int_detect;
  logic        int_en;
  logic [29:0] epc;
  logic [2:0]  exp_cause;

  // The sequencer itself
  modport slave (
    input  if_busy, mem_busy, ld_hazard, irq,
    input  mem_pc, mem_en, mem_br_flag, mem_exp_code,
    input  mem_ctrl_op, mem_cr_addr, mem_cr_wdata,
    output if_stall, id_stall, ex_stall, mem_stall,
    output if_flush, id_flush, ex_flush, mem_flush,
    output new_pc, int_detect, int_en, epc, exp_cause
  );

  // The pipeline side that feeds status in and consumes the controls
  modport master (
    output if_busy, mem_busy, ld_hazard, irq,
    output mem_pc, mem_en, mem_br_flag, mem_exp_code,
    output mem_ctrl_op, mem_cr_addr, mem_cr_wdata,
    input  if_stall, id_stall, ex_stall, mem_stall,
    input  if_flush, id_flush, ex_flush, mem_flush,
    input  new_pc, int_detect, int_en, epc, exp_cause
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central 5-stage pipeline sequencer: combinational stall/flush generation,
// interrupt gating, MEM-stage exception/eret/WRCR commit and the exception
// control registers (EPC, cause, interrupt enable + its saved copy).
module pipe_ctrl #(
  parameter logic [29:0] EXP_VECTOR   = 30'h0000_0100,
  parameter int          FLUSH_CYCLES = 1
) (
  input logic        clk,
  input logic        reset,
  pipe_ctrl_if.slave ctrl
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [1:0] OP_WRCR = 2'd1;
  localparam logic [1:0] OP_EXRT = 2'd2;
  localparam logic [2:0] FLUSH_LEN = 3'(FLUSH_CYCLES);

  state_t      state;
  state_t      state_next;
  logic [2:0]  flush_cnt;
  logic [2:0]  flush_cnt_next;
  logic [2:0]  flush_cnt_inc;
  logic [29:0] target;
  logic [29:0] epc_reg;
  logic [2:0]  cause_reg;
  logic        int_en_reg;
  logic        pre_int_en;

  logic        bus_stall;
  logic        commit_ok;
  logic        do_exp;
  logic        do_eret;
  logic        do_wrcr;
  logic        flushing;

  assign bus_stall     = ctrl.if_busy | ctrl.mem_busy;
  assign flushing      = (state == FLUSH);
  assign flush_cnt_inc = flush_cnt + 3'd1;

  // A MEM instruction may only commit while running and with MEM not held
  assign commit_ok = (state == RUN) & ~bus_stall & ctrl.mem_en;
  assign do_exp    = commit_ok & (ctrl.mem_exp_code != 3'd0);
  assign do_eret   = commit_ok & (ctrl.mem_exp_code == 3'd0) & (ctrl.mem_ctrl_op == OP_EXRT);
  assign do_wrcr   = commit_ok & (ctrl.mem_exp_code == 3'd0) & (ctrl.mem_ctrl_op == OP_WRCR);

  assign ctrl.int_en    = int_en_reg;
  assign ctrl.epc       = epc_reg;
  assign ctrl.exp_cause = cause_reg;

  // Sequencer state and flush-length counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      flush_cnt <= 3'd0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  // Next state plus the combinational stall/flush/redirect/interrupt outputs
  always_comb begin
    state_next      = state;
    flush_cnt_next  = flush_cnt;
    ctrl.if_stall   = bus_stall | ctrl.ld_hazard;
    ctrl.id_stall   = bus_stall | ctrl.ld_hazard;
    ctrl.ex_stall   = bus_stall;
    ctrl.mem_stall  = bus_stall;
    ctrl.if_flush   = flushing;
    ctrl.id_flush   = flushing;
    ctrl.ex_flush   = flushing | (ctrl.ld_hazard & ~bus_stall);
    ctrl.mem_flush  = flushing;
    ctrl.new_pc     = flushing ? target : 30'd0;
    ctrl.int_detect = ctrl.irq & int_en_reg & ~flushing & ~bus_stall & ~ctrl.ld_hazard;

    case (state)
      RUN: begin
        if (do_exp || do_eret) begin
          state_next     = FLUSH;
          flush_cnt_next = 3'd0;
        end
      end
      FLUSH: begin
        if (!bus_stall) begin
          if (flush_cnt_inc == FLUSH_LEN) begin
            state_next     = RUN;
            flush_cnt_next = 3'd0;
          end else begin
            flush_cnt_next = flush_cnt_inc;
          end
        end
      end
      default: begin
        state_next     = RUN;
        flush_cnt_next = 3'd0;
      end
    endcase
  end

  // Exception control registers and redirect target, updated on commit
  always_ff @(posedge clk) begin
    if (reset) begin
      target     <= 30'd0;
      epc_reg    <= 30'd0;
      cause_reg  <= 3'd0;
      int_en_reg <= 1'b0;
      pre_int_en <= 1'b0;
    end else if (do_exp) begin
      epc_reg    <= ctrl.mem_br_flag ? (ctrl.mem_pc - 30'd1) : ctrl.mem_pc;
      cause_reg  <= ctrl.mem_exp_code;
      pre_int_en <= int_en_reg;
      int_en_reg <= 1'b0;
      target     <= EXP_VECTOR;
    end else if (do_eret) begin
      int_en_reg <= pre_int_en;
      target     <= epc_reg;
    end else if (do_wrcr) begin
      case (ctrl.mem_cr_addr)
        2'd0: begin
          int_en_reg <= ctrl.mem_cr_wdata[0];
          pre_int_en <= ctrl.mem_cr_wdata[1];
        end
        2'd1:    cause_reg <= ctrl.mem_cr_wdata[2:0];
        2'd2:    epc_reg   <= ctrl.mem_cr_wdata[31:2];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (flush length 2 and 1) driven with the
// same stimulus, compared every cycle against a behavioural model, plus
// directed scenarios with hand-computed literal expectations.
module tb_pipe_ctrl;

  logic clk;
  logic rst;

  logic        s_if_busy, s_mem_busy, s_ld, s_irq;
  logic [29:0] s_pc;
  logic        s_en, s_br;
  logic [2:0]  s_code;
  logic [1:0]  s_op, s_addr;
  logic [31:0] s_wdata;

  int n_vec;
  int n_err;
  bit chk_on;

  pipe_ctrl_if if_a ();
  pipe_ctrl_if if_b ();

  pipe_ctrl #(.EXP_VECTOR(30'h0000_0100), .FLUSH_CYCLES(2)) dut_a (
    .clk(clk), .reset(rst), .ctrl(if_a.slave));
  pipe_ctrl #(.EXP_VECTOR(30'h0000_0100), .FLUSH_CYCLES(1)) dut_b (
    .clk(clk), .reset(rst), .ctrl(if_b.slave));

  assign if_a.if_busy = s_if_busy;     assign if_b.if_busy = s_if_busy;
  assign if_a.mem_busy = s_mem_busy;   assign if_b.mem_busy = s_mem_busy;
  assign if_a.ld_hazard = s_ld;        assign if_b.ld_hazard = s_ld;
  assign if_a.irq = s_irq;             assign if_b.irq = s_irq;
  assign if_a.mem_pc = s_pc;           assign if_b.mem_pc = s_pc;
  assign if_a.mem_en = s_en;           assign if_b.mem_en = s_en;
  assign if_a.mem_br_flag = s_br;      assign if_b.mem_br_flag = s_br;
  assign if_a.mem_exp_code = s_code;   assign if_b.mem_exp_code = s_code;
  assign if_a.mem_ctrl_op = s_op;      assign if_b.mem_ctrl_op = s_op;
  assign if_a.mem_cr_addr = s_addr;    assign if_b.mem_cr_addr = s_addr;
  assign if_a.mem_cr_wdata = s_wdata;  assign if_b.mem_cr_wdata = s_wdata;

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          flushing;
    int          left;
    logic [29:0] target;
    logic [29:0] epc;
    logic [2:0]  cause;
    bit          ie;
    bit          pie;
  } model_t;

  model_t m[2];
  int     flen[2] = '{2, 1};

  // Behavioural model: one architectural step per rising edge
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m[k].flushing = 0; m[k].left = 0; m[k].target = '0;
        m[k].epc = '0; m[k].cause = '0; m[k].ie = 0; m[k].pie = 0;
      end else if (m[k].flushing) begin
        if (!(s_if_busy || s_mem_busy)) begin
          m[k].left = m[k].left - 1;
          if (m[k].left == 0) m[k].flushing = 0;
        end
      end else if (!(s_if_busy || s_mem_busy) && s_en) begin
        if (s_code != 3'd0) begin
          m[k].epc = s_br ? 30'(s_pc - 30'd1) : s_pc;
          m[k].cause = s_code;
          m[k].pie = m[k].ie;
          m[k].ie = 0;
          m[k].target = 30'h100;
          m[k].flushing = 1;
          m[k].left = flen[k];
        end else if (s_op == 2'd2) begin
          m[k].ie = m[k].pie;
          m[k].target = m[k].epc;
          m[k].flushing = 1;
          m[k].left = flen[k];
        end else if (s_op == 2'd1) begin
          if (s_addr == 2'd0) begin m[k].ie = s_wdata[0]; m[k].pie = s_wdata[1]; end
          else if (s_addr == 2'd1) m[k].cause = s_wdata[2:0];
          else if (s_addr == 2'd2) m[k].epc = s_wdata[31:2];
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic check_output(input int k, input logic [3:0] st, input logic [3:0] fl,
                              input logic [29:0] npc, input logic intd, input logic ie,
                              input logic [29:0] epc, input logic [2:0] cause);
    bit bus;
    bit f;
    string tag;
    bus = s_if_busy | s_mem_busy;
    f   = m[k].flushing;
    tag = (k == 0) ? "a" : "b";
    check({tag, ".stalls"},     32'(st), 32'({bus | s_ld, bus | s_ld, bus, bus}));
    check({tag, ".flushes"},    32'(fl), 32'({f, f, f | (s_ld & ~bus), f}));
    check({tag, ".new_pc"},     32'(npc), 32'(f ? m[k].target : 30'd0));
    check({tag, ".int_detect"}, 32'(intd), 32'(s_irq & m[k].ie & ~f & ~bus & ~s_ld));
    check({tag, ".int_en"},     32'(ie), 32'(m[k].ie));
    check({tag, ".epc"},        32'(epc), 32'(m[k].epc));
    check({tag, ".exp_cause"},  32'(cause), 32'(m[k].cause));
  endtask

  // Compare both DUTs with the model away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      check_output(0, {if_a.if_stall, if_a.id_stall, if_a.ex_stall, if_a.mem_stall},
                   {if_a.if_flush, if_a.id_flush, if_a.ex_flush, if_a.mem_flush},
                   if_a.new_pc, if_a.int_detect, if_a.int_en, if_a.epc, if_a.exp_cause);
      check_output(1, {if_b.if_stall, if_b.id_stall, if_b.ex_stall, if_b.mem_stall},
                   {if_b.if_flush, if_b.id_flush, if_b.ex_flush, if_b.mem_flush},
                   if_b.new_pc, if_b.int_detect, if_b.int_en, if_b.epc, if_b.exp_cause);
    end
  end

  task automatic idle();
    rst = 0; s_if_busy = 0; s_mem_busy = 0; s_ld = 0; s_irq = 0;
    s_pc = '0; s_en = 0; s_br = 0; s_code = '0; s_op = '0; s_addr = '0; s_wdata = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic en, input logic [29:0] pc, input logic br,
                                input logic [2:0] code, input logic [1:0] op,
                                input logic [1:0] addr, input logic [31:0] wdata);
    s_en = en; s_pc = pc; s_br = br; s_code = code; s_op = op; s_addr = addr; s_wdata = wdata;
    cycle();
  endtask

  initial begin
    n_vec = 0; n_err = 0; chk_on = 0;
    idle();
    rst = 1;
    cycle();
    chk_on = 1;
    cycle();
    rst = 0;
    #1;
    check("reset.flush", 32'(if_a.if_flush), 32'd0);
    check("reset.epc", 32'(if_a.epc), 32'd0);
    check("reset.new_pc", 32'(if_a.new_pc), 32'd0);

    // Interrupt gating
    s_irq = 1; #1;
    check("irq.gated", 32'(if_a.int_detect), 32'd0);
    apply_stimulus(1, 30'h0, 0, 3'd0, 2'd1, 2'd0, 32'h1);
    s_en = 0; s_op = 0; #1;
    check("irq.enabled", 32'(if_a.int_detect), 32'd1);
    apply_stimulus(1, 30'h20, 0, 3'd1, 2'd0, 2'd0, 32'h0);
    #1;
    check("irq.commit.int_en", 32'(if_a.int_en), 32'd0);
    check("irq.commit.detect", 32'(if_a.int_detect), 32'd0);
    check("irq.commit.cause", 32'(if_a.exp_cause), 32'd1);
    idle(); repeat (3) cycle();

    // Overflow at MEM
    apply_stimulus(1, 30'h0, 0, 3'd0, 2'd1, 2'd0, 32'h1);
    apply_stimulus(1, 30'h40, 0, 3'd3, 2'd0, 2'd0, 32'h0);
    idle(); #1;
    check("ovf.flush", 32'(if_a.if_flush & if_a.id_flush & if_a.ex_flush & if_a.mem_flush), 32'd1);
    check("ovf.new_pc", 32'(if_a.new_pc), 32'h100);
    check("ovf.epc", 32'(if_a.epc), 32'h40);
    check("ovf.cause", 32'(if_a.exp_cause), 32'd3);
    check("ovf.int_en", 32'(if_a.int_en), 32'd0);
    cycle();
    check("ovf.len1.drop", 32'(if_b.if_flush), 32'd0);
    check("ovf.len2.hold", 32'(if_a.if_flush), 32'd1);
    repeat (3) cycle();

    // Delay-slot exception with PC wrap, then exception return
    apply_stimulus(1, 30'h0, 0, 3'd0, 2'd1, 2'd0, 32'h1);
    apply_stimulus(1, 30'h0, 1, 3'd5, 2'd0, 2'd0, 32'h0);
    idle(); #1;
    check("wrap.epc", 32'(if_a.epc), 32'h3FFF_FFFF);
    repeat (3) cycle();
    s_irq = 1;
    apply_stimulus(1, 30'h7, 0, 3'd0, 2'd2, 2'd0, 32'h0);
    idle(); #1;
    check("eret.new_pc", 32'(if_a.new_pc), 32'h3FFF_FFFF);
    check("eret.int_en", 32'(if_a.int_en), 32'd1);
    check("eret.flush", 32'(if_a.if_flush), 32'd1);
    repeat (3) cycle();

    // Load-use hazard, with and without a busy bus
    s_ld = 1; #1;
    check("ld.stalls", 32'({if_a.if_stall, if_a.id_stall, if_a.ex_stall, if_a.mem_stall}), 32'hC);
    check("ld.ex_flush", 32'(if_a.ex_flush), 32'd1);
    s_mem_busy = 1; #1;
    check("ld.busy.stalls", 32'({if_a.if_stall, if_a.id_stall, if_a.ex_stall, if_a.mem_stall}), 32'hF);
    check("ld.busy.ex_flush", 32'(if_a.ex_flush), 32'd0);
    cycle(); idle(); cycle();

    // Flush stretched by a busy bus; a commit during flush is ignored
    apply_stimulus(1, 30'h80, 0, 3'd2, 2'd0, 2'd0, 32'h0);
    s_code = 3'd4; #1;
    check("sflush.c1", 32'(if_a.if_flush), 32'd1);
    cycle();
    s_mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("sflush.busy", 32'(if_a.if_flush), 32'd1);
      cycle();
    end
    s_mem_busy = 0; #1;
    check("sflush.c5", 32'(if_a.if_flush), 32'd1);
    cycle();
    check("sflush.done", 32'(if_a.if_flush), 32'd0);
    check("sflush.ignored", 32'(if_a.exp_cause), 32'd2);
    idle(); repeat (3) cycle();

    // Reset in the middle of a flush
    apply_stimulus(1, 30'h10, 0, 3'd3, 2'd0, 2'd0, 32'h0);
    idle(); cycle();
    rst = 1; cycle();
    rst = 0; #1;
    check("rstmid.flush", 32'(if_a.if_flush | if_a.mem_flush), 32'd0);
    check("rstmid.new_pc", 32'(if_a.new_pc), 32'd0);
    check("rstmid.epc", 32'(if_a.epc), 32'd0);
    check("rstmid.cause", 32'(if_a.exp_cause), 32'd0);
    apply_stimulus(1, 30'h55, 0, 3'd6, 2'd0, 2'd0, 32'h0);
    idle(); #1;
    check("rstmid.exp.epc", 32'(if_a.epc), 32'h55);
    check("rstmid.exp.new_pc", 32'(if_a.new_pc), 32'h100);
    repeat (3) cycle();

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      s_if_busy  = ($urandom_range(0, 7) == 0);
      s_mem_busy = ($urandom_range(0, 7) == 0);
      s_ld       = ($urandom_range(0, 5) == 0);
      s_irq      = ($urandom_range(0, 2) == 0);
      s_pc       = 30'($urandom);
      s_en       = ($urandom_range(0, 3) != 0);
      s_br       = 1'($urandom);
      s_code     = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 6)) : 3'd0;
      s_op       = 2'($urandom);
      s_addr     = 2'($urandom);
      s_wdata    = $urandom;
      cycle();
    end

    idle();
    cycle();
    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
